// File: rtl/data_mem_lsu.sv
// Data memory with integrated RV32I load/store unit: combinational loads with
// byte/halfword extraction, byte-lane stores on the rising edge, fault tracking.
module data_mem_lsu #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        err_clr,
  output logic [31:0] rd_data,
  output logic        misaligned,
  output logic        err_sticky,
  output logic [31:0] store_count
);

  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [31:0]       cur_word;
  logic [31:0]       new_word;
  logic              ld_legal;
  logic              st_legal;
  logic              align_fault;
  logic              store_commit;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  // Upper address bits alias by design; collect them so they read as intentional.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign word_idx = addr[ADDR_W+1:2];
  assign lane     = addr[1:0];
  assign cur_word = mem[word_idx];

  assign ld_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
  assign st_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);

  // funct3[1:0] encodes access width: 00 byte, 01 half, 10 word.
  assign align_fault = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (lane != 2'b00));

  assign misaligned   = (re || we) &&
                        (align_fault || (re && !ld_legal) || (we && !st_legal));
  assign store_commit = we && st_legal && !align_fault;

  assign byte_sel = cur_word[{lane, 3'b000} +: 8];
  assign half_sel = addr[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    rd_data = '0;
    if (re && !misaligned) begin
      case (funct3)
        3'b000:  rd_data = {{24{byte_sel[7]}}, byte_sel};
        3'b001:  rd_data = {{16{half_sel[15]}}, half_sel};
        3'b010:  rd_data = cur_word;
        3'b100:  rd_data = {24'd0, byte_sel};
        3'b101:  rd_data = {16'd0, half_sel};
        default: rd_data = '0;
      endcase
    end
  end

  // Merge the store data into the addressed word, leaving other lanes intact.
  always_comb begin
    new_word = cur_word;
    case (funct3[1:0])
      2'b00: new_word[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: new_word[{addr[1], 4'b0000} +: 16] = wd[15:0];
      2'b10: new_word = wd;
      default: new_word = cur_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (store_commit) begin
      mem[word_idx] <= new_word;
    end
  end

  // Set has priority over clear so a fault in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky  <= 1'b0;
      store_count <= '0;
    end else begin
      if (misaligned)   err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
      if (store_commit) store_count <= store_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: vector table for the main load/store paths,
// hand sequences for fault stickiness, read-during-write and mid-cycle reset.
module tb_data_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic        re;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        err_clr;
  logic [31:0] rd_data;
  logic        misaligned;
  logic        err_sticky;
  logic [31:0] store_count;

  int checks;
  int failures;

  data_mem_lsu #(.DEPTH_WORDS(64), .ADDR_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .re          (re),
    .we          (we),
    .funct3      (funct3),
    .addr        (addr),
    .wd          (wd),
    .err_clr     (err_clr),
    .rd_data     (rd_data),
    .misaligned  (misaligned),
    .err_sticky  (err_sticky),
    .store_count (store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive at the falling edge so inputs are settled well before the next rising edge.
  task automatic drive(input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d, input logic clr);
    @(negedge clk);
    re = r; we = w; funct3 = f; addr = a; wd = d; err_clr = clr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; re = 1'b0; we = 1'b0; funct3 = 3'b010;
    addr = '0; wd = '0; err_clr = 1'b0;

    //            re    we    f3      addr      wd             exp_rd         mis   cnt
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h00, 32'h0,        32'h00000000, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 1'b0, 3'b010, 32'h04, 32'h0,        32'h00000000, 1'b0, 32'd0};
    vecs[2]  = '{1'b1, 1'b0, 3'b010, 32'hFC, 32'h0,        32'h00000000, 1'b0, 32'd0};
    vecs[3]  = '{1'b0, 1'b1, 3'b010, 32'h10, 32'h80F0A5C3, 32'h00000000, 1'b0, 32'd0};
    vecs[4]  = '{1'b1, 1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFC3, 1'b0, 32'd1};
    vecs[5]  = '{1'b1, 1'b0, 3'b100, 32'h11, 32'h0,        32'h000000A5, 1'b0, 32'd1};
    vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF80F0, 1'b0, 32'd1};
    vecs[7]  = '{1'b1, 1'b0, 3'b101, 32'h12, 32'h0,        32'h000080F0, 1'b0, 32'd1};
    vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h13, 32'h0000007E, 32'h00000000, 1'b0, 32'd1};
    vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'h7EF0A5C3, 1'b0, 32'd2};
    vecs[10] = '{1'b0, 1'b1, 3'b001, 32'h10, 32'h00001234, 32'h00000000, 1'b0, 32'd2};
    vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'h7EF01234, 1'b0, 32'd3};
    vecs[12] = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hCAFEF00D, 32'h00000000, 1'b0, 32'd3};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h00, 32'h0,        32'hCAFEF00D, 1'b0, 32'd4};
    vecs[14] = '{1'b0, 1'b0, 3'b010, 32'h10, 32'h0,        32'h00000000, 1'b0, 32'd4};

    // Reset held over a couple of edges, then released mid-cycle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].re, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, 1'b0);
      check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_misaligned", i), {31'd0, misaligned}, {31'd0, vecs[i].exp_mis});
      check($sformatf("vec%0d_store_count", i), store_count, vecs[i].exp_cnt);
      check($sformatf("vec%0d_err_sticky", i), {31'd0, err_sticky}, 32'd0);
    end

    // Misaligned word store is suppressed and sets the sticky flag.
    drive(1'b0, 1'b1, 3'b010, 32'h22, 32'hDEADBEEF, 1'b0);
    check("mis_sw_flag", {31'd0, misaligned}, 32'd1);
    drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
    check("mis_sw_no_write", rd_data, 32'h00000000);
    check("mis_sw_no_count", store_count, 32'd4);
    check("mis_sw_sticky_set", {31'd0, err_sticky}, 32'd1);

    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
    idle();
    check("err_clr_clears", {31'd0, err_sticky}, 32'd0);

    // Clear and a new fault in the same cycle: the fault wins.
    drive(1'b1, 1'b0, 3'b001, 32'h01, 32'h0, 1'b1);
    check("mis_lh_flag", {31'd0, misaligned}, 32'd1);
    check("mis_lh_rd_zero", rd_data, 32'h00000000);
    idle();
    check("set_beats_clear", {31'd0, err_sticky}, 32'd1);
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
    idle();
    check("err_clr_again", {31'd0, err_sticky}, 32'd0);

    // Read-during-write returns the pre-write word; the new value follows the edge.
    drive(1'b0, 1'b1, 3'b010, 32'h08, 32'h55AA55AA, 1'b0);
    drive(1'b1, 1'b1, 3'b010, 32'h08, 32'h11111111, 1'b0);
    check("rdw_old_value", rd_data, 32'h55AA55AA);
    drive(1'b1, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0);
    check("rdw_new_value", rd_data, 32'h11111111);
    check("rdw_store_count", store_count, 32'd6);

    // Leave the sticky flag set so its asynchronous clear is observable.
    drive(1'b1, 1'b0, 3'b010, 32'h02, 32'h0, 1'b0);
    idle();
    check("pre_reset_sticky", {31'd0, err_sticky}, 32'd1);

    // Asynchronous reset lands with a store pending to word 1.
    drive(1'b0, 1'b1, 3'b010, 32'h04, 32'h99999999, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_count_immediate", store_count, 32'd0);
    check("rst_sticky_immediate", {31'd0, err_sticky}, 32'd0);
    drive(1'b1, 1'b0, 3'b010, 32'h04, 32'h0, 1'b0);
    check("rst_word1_zero", rd_data, 32'h00000000);
    drive(1'b1, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0);
    check("rst_word2_zero", rd_data, 32'h00000000);
    drive(1'b1, 1'b0, 3'b011, 32'h00, 32'h0, 1'b0);
    check("illegal_f3_rd", rd_data, 32'h00000000);
    check("illegal_f3_mis", {31'd0, misaligned}, 32'd1);
    check("rst_count_held", store_count, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    re = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h04;
    @(negedge clk);
    check("post_rst_word1", rd_data, 32'h00000000);
    check("post_rst_count", store_count, 32'd0);
    check("post_rst_sticky", {31'd0, err_sticky}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
